// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Executes one load or store command at a time against a simple
// request/acknowledge data memory. The effective address is the base
// register value plus a sign-extended 8-bit offset. Addresses that do not fit
// in the memory address space are rejected without touching memory. Loads
// write the returned word back to the register file for exactly one cycle.
// A memory that never acknowledges is abandoned after TIMEOUT request cycles.
//
// Ports
//   reg_clk, reg_rst       clock (rising edge), async active-high reset
//   ls_valid / ls_ready    command handshake; ready only while idle
//   ls_is_store            1 = store, 0 = load
//   ls_base, ls_offset     base address and signed byte offset
//   ls_rd                  load destination register index
//   ls_store_data          store data
//   mem_req, mem_we        memory request and write enable
//   mem_addr, mem_wdata    memory address and write data
//   mem_ack, mem_rdata     memory completion and read data
//   wb_we, wb_addr,wb_data register-file writeback port
//   ls_done, ls_err        one-cycle completion / error pulses
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int SIZE    = 24,
   parameter int MEM_AW  = 16,
   parameter int TIMEOUT = 16
) (
   input  logic              reg_clk,
   input  logic              reg_rst,
   input  logic              ls_valid,
   output logic              ls_ready,
   input  logic              ls_is_store,
   input  logic [SIZE-1:0]   ls_base,
   input  logic [7:0]        ls_offset,
   input  logic [3:0]        ls_rd,
   input  logic [SIZE-1:0]   ls_store_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [SIZE-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [SIZE-1:0]   mem_rdata,
   output logic              wb_we,
   output logic [3:0]        wb_addr,
   output logic [SIZE-1:0]   wb_data,
   output logic              ls_done,
   output logic              ls_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WB,
      DONE,
      ERR
   } state_t;

   state_t              state_q, state_d;
   logic                is_store_q, is_store_d;
   logic [3:0]          rd_q, rd_d;
   logic [SIZE-1:0]     wdata_q, wdata_d;
   logic [MEM_AW-1:0]   addr_q, addr_d;
   logic [SIZE-1:0]     rdata_q, rdata_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [SIZE-1:0]     off_ext;
   logic [SIZE-1:0]     ea;
   logic                addr_err;

   // Effective address wraps modulo 2^SIZE; any set bit above the memory
   // address width means the access falls outside the data memory.
   assign off_ext  = {{(SIZE-8){ls_offset[7]}}, ls_offset};
   assign ea       = ls_base + off_ext;
   assign addr_err = |ea[SIZE-1:MEM_AW];

   // Next-state and latch updates. Commands are only looked at while idle,
   // and mem_ack is only looked at while a request is outstanding, so stray
   // handshakes in any other state have no effect. An ack in the final
   // allowed request cycle takes priority over the timeout.
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      rd_d       = rd_q;
      wdata_d    = wdata_q;
      addr_d     = addr_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE: begin
            if (ls_valid) begin
               is_store_d = ls_is_store;
               rd_d       = ls_rd;
               wdata_d    = ls_is_store ? ls_store_data : '0;
               cnt_d      = '0;
               if (addr_err) begin
                  state_d = ERR;
               end else begin
                  addr_d  = ea[MEM_AW-1:0];
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (is_store_q) begin
                  state_d = DONE;
               end else begin
                  rdata_d = mem_rdata;
                  state_d = WB;
               end
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WB:      state_d = DONE;
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latch registers; reset aborts any transaction immediately.
   always_ff @(posedge reg_clk or posedge reg_rst) begin
      if (reg_rst) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         rd_q       <= '0;
         wdata_q    <= '0;
         addr_q     <= '0;
         rdata_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         rd_q       <= rd_d;
         wdata_q    <= wdata_d;
         addr_q     <= addr_d;
         rdata_q    <= rdata_d;
         cnt_q      <= cnt_d;
      end
   end

   // Outputs are decoded purely from the state register and the latches,
   // so they are glitch-free and never depend combinationally on inputs.
   assign ls_ready  = (state_q == IDLE);
   assign mem_req   = (state_q == REQ);
   assign mem_we    = (state_q == REQ) && is_store_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign wb_we     = (state_q == WB);
   assign wb_addr   = rd_q;
   assign wb_data   = rdata_q;
   assign ls_done   = (state_q == DONE);
   assign ls_err    = (state_q == ERR);

endmodule
